// File: rtl/axis_frame_receiver.sv
// AXI-Stream multichannel frame receiver: checks tlast framing, demultiplexes
// frames into a ping-pong pair of buffers and backpressures when both hold unread frames.
module axis_frame_receiver #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_CH   = 16,
    parameter int unsigned CH_W   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [CH_W-1:0]   channel_No,
    output logic              frame_valid,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_data,
    input  logic              frame_ack,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic {
        FILL,
        RESYNC
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [2][N_CH];
    logic              accept;
    logic              mem_we;

    // Ready is forced low while reset is asserted so no beat is taken during reset.
    assign s_axis_tready = !rst && ((state_q == RESYNC) || !full_q[wr_bank_q]);
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign channel_No  = ch_q;
    assign frame_valid = full_q[rd_bank_q];
    assign rd_data     = rd_data_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        frame_err_d = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        mem_we      = 1'b0;

        // Release is applied before completion so a same-cycle ack and fill of
        // different banks both land; an ack of an empty bank is simply dropped.
        if (frame_ack && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end

        if (accept) begin
            case (state_q)
                FILL: begin
                    mem_we = 1'b1;
                    if (ch_q == LAST_CH) begin
                        ch_d = '0;
                        if (s_axis_tlast) begin
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = !wr_bank_q;
                            if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                            state_d = RESYNC;
                        end
                    end else if (s_axis_tlast) begin
                        ch_d        = '0;
                        frame_err_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end
                RESYNC: begin
                    if (s_axis_tlast) state_d = FILL;
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            ch_q        <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            rd_data_q   <= mem_q[rd_bank_q][rd_ch];
        end
    end

    // Frame storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_bank_q][ch_q] <= s_axis_tdata;
    end

endmodule

// File: doc/axis_frame_receiver.md
Name: axis_frame_receiver

Overview:
- Receive end of the multichannel sample stream. The transmit side tags interleaved per-channel samples and asserts tlast on the last channel (N_CH-1). This block checks that framing and demultiplexes each frame into a ping-pong pair of frame buffers.
- Downstream logic (spike detector / DMA packer) reads one complete frame at random channel address, then releases it with frame_ack.
- Applies AXI-Stream backpressure when both buffers hold unread frames.

Parameters:
- DATA_W, 32, sample width in bits.
- N_CH, 16, channels per frame; last channel index N_CH-1 carries tlast.
- CH_W, 4, channel index width; must satisfy 2^CH_W >= N_CH.
- CNT_W, 16, width of the frame and error counters.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_W  sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  block can accept a sample.
- s_axis_tlast  in  1  end of frame marker.
- channel_No  out  CH_W  channel index expected for the next accepted beat.
- frame_valid  out  1  a complete frame is readable.
- rd_ch  in  CH_W  read channel address.
- rd_data  out  DATA_W  sample at rd_ch of the readable frame; 1-cycle latency.
- frame_ack  in  1  release the readable frame.
- frame_err  out  1  one-cycle pulse on a framing error.
- frame_cnt  out  CNT_W  good frames received, saturating.
- err_cnt  out  CNT_W  framing errors, saturating.

Behaviour:
- Reset values: all outputs 0; both banks empty; wr_bank=0; rd_bank=0; ch=0; state=FILL.
- s_axis_tready is 0 while rst is high. It may be 1 in the first cycle after rst deasserts.
- Beat accept: s_axis_tvalid && s_axis_tready.
- s_axis_tready = 1 in RESYNC. In FILL, s_axis_tready = !full[wr_bank].
- State FILL, on each accepted beat: write tdata to bank[wr_bank][ch], then:
  - ch<N_CH-1, !tlast: ch++.
  - ch==N_CH-1, tlast: full[wr_bank]<=1; wr_bank flips; ch<=0; frame_cnt++.
  - ch<N_CH-1, tlast (early tlast): frame_err pulse; err_cnt++; ch<=0; partial frame discarded (bank not marked full, wr_bank unchanged). The next beat is channel 0.
  - ch==N_CH-1, !tlast (missing tlast): frame_err pulse; err_cnt++; ch<=0; frame discarded; go to RESYNC.
- State RESYNC: accept and drop every beat; no buffer writes. On an accepted beat with tlast, go to FILL. The next beat is channel 0.
- channel_No = ch. It holds 0 in RESYNC.
- Read side:
  - frame_valid = full[rd_bank].
  - rd_data is registered: it reflects bank[rd_bank][rd_ch] sampled at the previous clock edge.
  - frame_ack while frame_valid=1: full[rd_bank]<=0 and rd_bank flips; frame_valid may rise the next cycle if the other bank is full.
  - frame_ack while frame_valid=0 is ignored.
- Latency: last beat accepted at edge N gives frame_valid=1 after edge N (visible in cycle N+1), provided the bank was free.
- Simultaneous events:
  - Frame completion and frame_ack in the same cycle both take effect.
  - If wr_bank==rd_bank and the bank was empty, completion sets full and the ack is ignored.
- Counters saturate at all ones; they never wrap.
- Reset mid-frame discards partial and buffered frames.
- The buffers are a register array or distributed RAM, 2*N_CH*DATA_W bits.

Test Plan:
- Reset, then 16 beats with data=0x100+ch and tlast on beat 15 -> frame_valid=1 the cycle after the last beat. Sweeping rd_ch 0..15 returns 0x100..0x10F with 1-cycle latency. frame_cnt=1, err_cnt=0.
- Three back-to-back frames, no frame_ack -> tready drops after frame 2 completes; frame 3 is stalled with no data loss. After frame_ack, frame 2 is readable, tready returns, and frame 3 completes. frame_cnt=3.
- tlast on beat 5 -> frame_err pulses 1 cycle; err_cnt=1; no frame_valid. The following 16-beat frame is received correctly with channel 0 = first beat after the error.
- 20 beats with no tlast, then tlast on beat 24 -> frame_err at beat 16; beats 17..24 dropped; the next 16-beat frame is good. err_cnt=1, frame_cnt=1.
- frame_ack in the same cycle as completion of the other bank -> both banks handled; frame_valid stays 1 and shows the new frame. frame_ack with frame_valid=0 -> no change.
- Assert rst after 8 beats of a frame and with one full bank -> all outputs 0, frame_valid=0. A fresh frame afterwards lands in bank 0 correctly.
